// File: rtl/branch_cond_unit.sv
// Branch condition evaluator with a write-forwarded flag register and a one-entry
// output register. Define COND_UNSIGNED_EN to honour req_cond[3] (unsigned mode).
//
// state | meaning
// EMPTY | no result held, out_valid=0
// FULL  | result held in out_taken, out_valid=1
module branch_cond_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic [WIDTH-1:0] flag_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [15:0]      taken_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] f_reg;
  logic [WIDTH-1:0] v;
  logic             uns_mode;
  logic             v_zero;
  logic             v_neg;
  logic             taken_n;
  logic             accept;

  // Evaluate against the value being written this cycle, if any.
  assign v         = flag_we ? flag_in : f_reg;
  assign out_valid = (state == FULL);
  assign req_ready = !out_valid || out_ready;
  assign accept    = req_valid && req_ready;

`ifdef COND_UNSIGNED_EN
  assign uns_mode = req_cond[3];
`else
  logic unused_cond_msb;
  assign unused_cond_msb = req_cond[3];
  assign uns_mode = 1'b0;
`endif

  // In unsigned mode nothing is negative, which folds the unsigned table
  // onto the signed one.
  assign v_zero = (v == '0);
  assign v_neg  = v[WIDTH-1] && !uns_mode;

  always_comb begin
    taken_n = 1'b0;
    case (req_cond[2:0])
      3'b000:  taken_n = 1'b0;
      3'b001:  taken_n = v_zero;
      3'b010:  taken_n = v_neg;
      3'b011:  taken_n = v_neg || v_zero;
      3'b100:  taken_n = 1'b1;
      3'b101:  taken_n = !v_zero;
      3'b110:  taken_n = !v_neg;
      3'b111:  taken_n = !v_neg && !v_zero;
      default: taken_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      f_reg     <= '0;
      out_taken <= 1'b0;
      taken_cnt <= 16'd0;
    end else begin
      if (flag_we)
        f_reg <= flag_in;
      if (out_valid && out_ready && out_taken)
        taken_cnt <= taken_cnt + 16'd1;
      case (state)
        EMPTY: begin
          if (accept) begin
            out_taken <= taken_n;
            state     <= FULL;
          end
        end
        FULL: begin
          if (accept)
            out_taken <= taken_n;
          else if (out_ready)
            state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed cases plus random traffic
// compared against a queue-based reference model.
module tb_branch_cond_unit;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         flag_we;
  logic [W-1:0] flag_in;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_cond;
  logic         out_valid;
  logic         out_ready;
  logic         out_taken;
  logic [15:0]  taken_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mdl_f;
  bit           mdl_q[$];
  logic [15:0]  mdl_cnt;

  branch_cond_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flag_we   (flag_we),
    .flag_in   (flag_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cond  (req_cond),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_taken (out_taken),
    .taken_cnt (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Condition result from plain integer comparisons.
  function automatic bit ref_taken(input logic [3:0] c, input logic [W-1:0] v);
    longint val;
    bit     uns;
    uns = 1'b0;
`ifdef COND_UNSIGNED_EN
    uns = c[3];
`endif
    val = uns ? longint'(v) : longint'($signed(v));
    case (c[2:0])
      3'd0:    return 1'b0;
      3'd1:    return val == 0;
      3'd2:    return val < 0;
      3'd3:    return val <= 0;
      3'd4:    return 1'b1;
      3'd5:    return val != 0;
      3'd6:    return val >= 0;
      default: return val > 0;
    endcase
  endfunction

  task automatic model_reset();
    mdl_f   = '0;
    mdl_q   = {};
    mdl_cnt = 16'd0;
  endtask

  // One clock: check req_ready before the edge, advance the model, compare after.
  task automatic cycle();
    logic [W-1:0] v;
    bit           rdy;
    bit           t;
    #1;
    v   = flag_we ? flag_in : mdl_f;
    rdy = (mdl_q.size() == 0) || out_ready;
    chk("req_ready", req_ready, rdy);
    if (mdl_q.size() != 0 && out_ready) begin
      t = mdl_q.pop_front();
      if (t) mdl_cnt = mdl_cnt + 16'd1;
    end
    if (req_valid && rdy) mdl_q.push_back(ref_taken(req_cond, v));
    if (flag_we) mdl_f = flag_in;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, mdl_q.size() != 0);
    if (mdl_q.size() != 0) chk("out_taken", out_taken, mdl_q[0]);
    chk("taken_cnt", taken_cnt, mdl_cnt);
  endtask

  task automatic drive(input bit we, input logic [W-1:0] fi, input bit rv,
                       input logic [3:0] c, input bit ordy);
    flag_we   = we;
    flag_in   = fi;
    req_valid = rv;
    req_cond  = c;
    out_ready = ordy;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 4'b0000, 1'b1);
  endtask

  logic [7:0]  exp030;
  logic [15:0] cnt_before;
  bit          exp_a;
  bit          exp_b;

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_taken", out_taken, 1'b0);
    chk("rst_cnt", taken_cnt, 16'd0);
    chk("rst_ready", req_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Flags read as zero before the first write.
    drive(1'b0, '0, 1'b1, 4'b0001, 1'b1); cycle();
    chk("v0_eq", out_taken, 1'b1);
    drive(1'b0, '0, 1'b1, 4'b0010, 1'b1); cycle();
    chk("v0_lt", out_taken, 1'b0);
    idle(); cycle();

    // 0x80 against every signed code, one result per cycle.
    exp030 = 8'b0011_1100;
    drive(1'b1, 8'h80, 1'b0, 4'b0000, 1'b1); cycle();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, 4'(i), 1'b1); cycle();
      chk($sformatf("x80_code%0d", i), out_taken, exp030[i]);
    end
    idle(); cycle();

    // Same-cycle write is forwarded to the evaluation.
    drive(1'b1, 8'h05, 1'b0, 4'b0000, 1'b1); cycle();
    drive(1'b1, 8'h00, 1'b1, 4'b0001, 1'b1); cycle();
    chk("fwd_zero", out_taken, 1'b1);
    idle(); cycle();

    // Unsigned mode on 0xFF.
`ifdef COND_UNSIGNED_EN
    exp_a = 1'b1; exp_b = 1'b0;
`else
    exp_a = 1'b0; exp_b = 1'b1;
`endif
    drive(1'b1, 8'hFF, 1'b0, 4'b0000, 1'b1); cycle();
    drive(1'b0, '0, 1'b1, 4'b1111, 1'b1); cycle();
    chk("ff_c1111", out_taken, exp_a);
    drive(1'b0, '0, 1'b1, 4'b1010, 1'b1); cycle();
    chk("ff_c1010", out_taken, exp_b);
    idle(); cycle();

    // Backpressure: held result survives a flag write, then delivered.
    drive(1'b1, 8'h00, 1'b1, 4'b0001, 1'b0); cycle();
    cnt_before = taken_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(i == 1, 8'h7F, 1'b1, 4'b0001, 1'b0);
      cycle();
      chk("bp_ready", req_ready, 1'b0);
      chk("bp_held", out_taken, 1'b1);
    end
    drive(1'b0, '0, 1'b0, 4'b0000, 1'b1); cycle();
    chk("bp_cnt", taken_cnt, cnt_before + 16'd1);
    chk("bp_empty", out_valid, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) == 0), W'($urandom), $urandom_range(0, 1),
            4'($urandom), ($urandom_range(0, 3) != 0));
      cycle();
    end

    // Reset while holding a taken result.
    drive(1'b1, 8'h33, 1'b1, 4'b0100, 1'b0); cycle();
    chk("pre_rst_full", out_valid, 1'b1);
    reset = 1'b1;
    #2;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_cnt", taken_cnt, 16'd0);
    chk("mid_rst_taken", out_taken, 1'b0);
    reset = 1'b0;
    model_reset();
    drive(1'b0, '0, 1'b1, 4'b0001, 1'b1); cycle();
    chk("post_rst_f0", out_taken, 1'b1);
    idle(); cycle();

    // Counter wrap: 65535 taken deliveries, then one more.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    drive(1'b0, '0, 1'b1, 4'b0100, 1'b1);
    repeat (65536) @(posedge clk);
    #1;
    chk("cnt_ffff", taken_cnt, 16'hFFFF);
    idle();
    @(posedge clk);
    #1;
    chk("cnt_wrap", taken_cnt, 16'h0000);
    chk("cnt_wrap_empty", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port flag_we, input, 1 bit: when 1, capture flag_in into the flag register.
REQ-005 SHALL have port flag_in, input, WIDTH bits: the value to capture, two's complement.
REQ-006 SHALL have port req_valid, input, 1 bit: an evaluation request is present.
REQ-007 SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-008 SHALL have port req_cond, input, 4 bits: bits [2:0] are the condition code and bit [3] selects unsigned mode.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is held.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the held result.
REQ-011 SHALL have port out_taken, output, 1 bit: the condition result.
REQ-012 SHALL have port taken_cnt, output, 16 bits: the count of results delivered with out_taken=1.

Function
REQ-013 SHALL hold the flag register F (WIDTH bits) and load F<=flag_in on each rising edge with flag_we=1.
REQ-014 SHALL take the evaluation operand V as flag_in when flag_we=1 in the request cycle, else as F (write-forwarding).
REQ-015 SHALL decode req_cond[2:0], signed mode: 000 false; 001 V==0; 010 V<0; 011 V<=0; 100 true; 101 V!=0; 110 V>=0; 111 V>0.
REQ-016 SHALL, when req_cond[3]=1 and COND_UNSIGNED_EN is defined, treat V as unsigned: 010 false; 011 V==0; 110 true; 111 V!=0; the other codes as in signed mode.
REQ-017 SHALL use a one-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 SHALL drive req_ready = !out_valid || out_ready (combinational).
REQ-019 SHALL accept a request on req_valid && req_ready, load out_taken, and be FULL at the next edge: latency 1 cycle.
REQ-020 SHALL, when FULL with out_ready=1 and no new accept, return to EMPTY.
REQ-021 SHALL, when FULL with out_ready=1 and req_valid=1, deliver and reload in the same edge with no bubble (stays FULL).
REQ-022 SHALL keep out_taken stable while FULL and out_ready=0; later flag writes do not alter a held result.
REQ-023 SHALL increment taken_cnt on each edge where out_valid && out_ready && out_taken, wrapping 0xFFFF->0x0000.
REQ-024 SHALL ignore req_valid while req_ready=0; the request is not lost, it is the producer's duty to hold it.

Reset
REQ-025 SHALL, while reset=1, asynchronously force F=0, out_valid=0, out_taken=0 and taken_cnt=0.
REQ-026 SHALL discard any held result on reset mid-operation; it is not delivered and not counted.
REQ-027 SHALL evaluate flags as V=0 before the first flag write after reset (001 true, 010 false).

Configuration
REQ-028 SHALL, with COND_UNSIGNED_EN defined, honour req_cond[3] per REQ-016.
REQ-029 SHALL, without COND_UNSIGNED_EN, ignore req_cond[3] and always use signed mode.

Verification
REQ-030 SHALL cover: WIDTH=8, write 0x80 then request each cond[2:0] -> taken 0,0,1,1,1,1,0,0 for codes 000..111, one result per cycle with out_ready=1.
REQ-031 SHALL cover: flag_we=1 with flag_in=0x00 and req_cond=0001 in the same cycle, F previously 0x05 -> out_taken=1 (forwarded).
REQ-032 SHALL cover: COND_UNSIGNED_EN defined, F=0xFF, req_cond=1111 -> taken=1; req_cond=1010 -> taken=0; macro undefined with req_cond=1010 -> taken=1.
REQ-033 SHALL cover: out_ready=0 for 3 cycles with FULL -> req_ready=0, out_taken held through a flag write; then out_ready=1 -> delivered, taken_cnt +1.
REQ-034 SHALL cover: reset asserted while FULL with taken=1 -> out_valid=0 immediately, taken_cnt=0, F=0.
REQ-035 SHALL cover: taken_cnt preset to 0xFFFF by 65535 taken deliveries, one more -> 0x0000.
